cl_compute_request_packer: RTL
==============================

# cl_compute_request_packer

Gathers one 32-bit word from each of `NUM_FIELDS` independent AXI-stream-style field lanes and packs them into one compute-request word. The packed word is written into the compute-request FIFO that feeds the compute engine's stream separator, so this block is the inverse of that separator. Each lane has its own capture register, so lanes may arrive in any order and at any skew. A registered output stage supports FIFO back-pressure and sustains one request per cycle.

## Interface
Parameters:
- `NUM_FIELDS`, 17: number of field lanes per request.
- `FIELD_WIDTH`, 32: bits per field.

Ports:
- `clock_i`  in  1: single clock; all logic is rising-edge.
- `reset_n_i`  in  1: reset, synchronous and active-low.
- `s_tdata_i`  in  `NUM_FIELDS`×`FIELD_WIDTH`: per-lane field data, unpacked array indexed by lane.
- `s_tvalid_i`  in  `NUM_FIELDS`: per-lane valid.
- `s_tready_o`  out  `NUM_FIELDS`: per-lane ready.
- `fifo_data_o`  out  `NUM_FIELDS*FIELD_WIDTH`: packed request word; lane k occupies bits `[k*FIELD_WIDTH +: FIELD_WIDTH]`, lane 0 in the LSBs.
- `fifo_write_o`  out  1: FIFO write strobe.
- `fifo_full_i`  in  1: FIFO full.
- `words_written_o`  out  32: count of words written to the FIFO.
- `busy_o`  out  1: high when any lane is loaded or the output register is valid.

## Operation
- Per-lane state is `loaded[k]` plus a capture register `field_q[k]`.
- `transfer = &loaded && (!out_valid || !fifo_full_i)`.
- Ready rule: `s_tready_o[k] = !loaded[k] || transfer`.
- Lane handshake: `s_tvalid_i[k] && s_tready_o[k]` captures `s_tdata_i[k]` and sets `loaded[k]`.
- When `transfer` is high:
  - all `field_q` values are copied into the output register and `out_valid` is set;
  - every `loaded[k]` clears, unless that lane handshakes in the same cycle, in which case it stays set with the new data.
- Gather state machine:
  - GATHER: at least one lane not loaded. Go to COMPLETE when the last missing lane handshakes.
  - COMPLETE: all lanes loaded. Go back to GATHER on `transfer`, unless all lanes reload in that cycle, in which case stay in COMPLETE.
- Output stage:
  - EMPTY (`out_valid` = 0) and FULL (`out_valid` = 1).
  - `fifo_write_o = out_valid && !fifo_full_i`.
  - FULL→EMPTY on a write with no simultaneous `transfer`. FULL stays FULL on write plus `transfer`.
  - `fifo_data_o` is driven directly from the output register and holds stable while `out_valid && fifo_full_i`.
- `words_written_o` increments on each `fifo_write_o`; wraps 0xFFFF_FFFF→0.
- A lane holding valid data is never overwritten: `s_tready_o[k]` stays low until `transfer`.
- `s_tvalid_i` may drop without a handshake; that lane then simply remains unloaded.

## Timing
- Reset values while `reset_n_i` = 0 at a clock edge:
  - all `loaded` = 0, `out_valid` = 0, `fifo_write_o` = 0, `fifo_data_o` = 0, `words_written_o` = 0, `busy_o` = 0;
  - `s_tready_o` = all ones from the first cycle after reset.
- Reset mid-operation discards partial gathers and any unwritten output word. No FIFO write occurs in the reset cycle.
- Latency: last lane handshake in cycle t → `transfer` in t+1 → `fifo_write_o` = 1 in t+2 (FIFO not full).
- Throughput: one request per cycle when all lanes present valid every cycle and the FIFO is not full.
- Combinational paths: `fifo_full_i` → `s_tready_o` and `fifo_full_i` → `fifo_write_o` are allowed. There is no path from `s_tvalid_i` to `s_tready_o`.
- FIFO full while the output is FULL and all lanes are loaded: every `s_tready_o` = 0, no state change.

## Structure
- `FIELD_WIDTH`, the default `NUM_FIELDS`, and a lane-index enum go in `PairHMMPackage`, shared with the stream separator.
- The enum order (`TOP_INSERTION`=0 … `ID`=16) matches the separator's unpack order.
- The lane logic is one natural sub-module, `cl_field_capture_slot`: one lane's register, loaded flag and ready, instantiated `NUM_FIELDS` times by generate.
- Output stage and counter stay in the top module.

## Test plan
- Single request: lane k drives `32'h100+k`, all valid in cycle 0 → `fifo_write_o` = 1 in cycle 2 with lane k's `32'h100+k` in bits `[32k+:32]`; `words_written_o` = 1.
- Skewed arrival: lane k valid only in cycle k (k = 0..16):
  - no write before cycle 18, one write in cycle 18;
  - after its own handshake, each lane sees `s_tready_o[k]` = 0 until cycle 17.
- Back-pressure: `fifo_full_i` = 1 for 10 cycles while 3 requests are offered:
  - `fifo_data_o` is held stable throughout;
  - exactly 3 writes occur after full releases, in order, with no loss or duplication.
- Streaming: 100 back-to-back requests with FIFO never full → 100 consecutive `fifo_write_o` cycles starting at cycle 2.
- Reset mid-gather: 8 lanes loaded, then `reset_n_i` = 0 for one cycle → no write; the next complete request produces exactly one correct word and `words_written_o` = 1.
- Counter wrap: force the count to 0xFFFF_FFFF, then one write → `words_written_o` = 0.

Source files
------------

// File: rtl/cl_compute_request_packer_pkg.sv
// Shared definitions for the compute-request packer and the compute engine's stream separator.
// Lane order must match the separator's unpack order.
package PairHMMPackage;

  localparam int unsigned FIELD_WIDTH = 32;
  localparam int unsigned NUM_FIELDS  = 17;

  typedef enum logic [4:0] {
    TOP_INSERTION          = 5'd0,
    TOP_DELETION           = 5'd1,
    TOP_MATCH              = 5'd2,
    LEFT_INSERTION         = 5'd3,
    LEFT_DELETION          = 5'd4,
    LEFT_MATCH             = 5'd5,
    DIAG_INSERTION         = 5'd6,
    DIAG_DELETION          = 5'd7,
    DIAG_MATCH             = 5'd8,
    MATCH_TO_MATCH         = 5'd9,
    INSERTION_TO_MATCH     = 5'd10,
    INSERTION_TO_INSERTION = 5'd11,
    DELETION_TO_MATCH      = 5'd12,
    DELETION_TO_DELETION   = 5'd13,
    READ_BASE              = 5'd14,
    HAP_BASE               = 5'd15,
    ID                     = 5'd16
  } field_lane_e;

  typedef enum logic [0:0] {
    StGather   = 1'b0,
    StComplete = 1'b1
  } gather_state_e;

endpackage

// File: rtl/cl_field_capture_slot.sv
// One field lane: capture register, loaded flag and ready.
// A loaded lane refuses new data until the whole request moves to the output register.
module cl_field_capture_slot #(
  parameter int unsigned Width = PairHMMPackage::FIELD_WIDTH
) (
  input  logic             clock_i,
  input  logic             reset_n_i,
  input  logic [Width-1:0] data_i,
  input  logic             valid_i,
  input  logic             transfer_i,
  output logic             ready_o,
  output logic             handshake_o,
  output logic             loaded_o,
  output logic [Width-1:0] field_o
);

  logic             loaded_q, loaded_d;
  logic [Width-1:0] field_q, field_d;

  assign ready_o     = !loaded_q || transfer_i;
  assign handshake_o = valid_i && ready_o;
  assign loaded_o    = loaded_q;
  assign field_o     = field_q;

  always_comb begin
    loaded_d = loaded_q;
    field_d  = field_q;
    // A handshake in the transfer cycle refills the lane with the next request's data.
    if (handshake_o) begin
      loaded_d = 1'b1;
      field_d  = data_i;
    end else if (transfer_i) begin
      loaded_d = 1'b0;
    end
  end

  always_ff @(posedge clock_i) begin
    if (!reset_n_i) begin
      loaded_q <= 1'b0;
      field_q  <= '0;
    end else begin
      loaded_q <= loaded_d;
      field_q  <= field_d;
    end
  end

endmodule

// File: rtl/cl_compute_request_packer.sv
// Gathers one field per lane into a packed compute-request word and writes it to the
// compute-request FIFO through a registered, back-pressure-aware output stage.
module cl_compute_request_packer #(
  parameter int unsigned NUM_FIELDS  = PairHMMPackage::NUM_FIELDS,
  parameter int unsigned FIELD_WIDTH = PairHMMPackage::FIELD_WIDTH
) (
  input  logic                              clock_i,
  input  logic                              reset_n_i,
  input  logic [FIELD_WIDTH-1:0]            s_tdata_i [NUM_FIELDS],
  input  logic [NUM_FIELDS-1:0]             s_tvalid_i,
  output logic [NUM_FIELDS-1:0]             s_tready_o,
  output logic [NUM_FIELDS*FIELD_WIDTH-1:0] fifo_data_o,
  output logic                              fifo_write_o,
  input  logic                              fifo_full_i,
  output logic [31:0]                       words_written_o,
  output logic                              busy_o
);

  localparam int unsigned DataWidth = NUM_FIELDS * FIELD_WIDTH;

  logic [NUM_FIELDS-1:0]     loaded;
  logic [NUM_FIELDS-1:0]     handshake;
  logic [FIELD_WIDTH-1:0]    field [NUM_FIELDS];
  logic [DataWidth-1:0]      packed_fields;
  logic                      transfer;
  logic                      fifo_write;

  PairHMMPackage::gather_state_e state_q, state_d;

  logic                 out_valid_q, out_valid_d;
  logic [DataWidth-1:0] out_data_q, out_data_d;
  logic [31:0]          words_q, words_d;

  for (genvar k = 0; k < NUM_FIELDS; k++) begin : g_slot
    cl_field_capture_slot #(
      .Width(FIELD_WIDTH)
    ) u_slot (
      .clock_i    (clock_i),
      .reset_n_i  (reset_n_i),
      .data_i     (s_tdata_i[k]),
      .valid_i    (s_tvalid_i[k]),
      .transfer_i (transfer),
      .ready_o    (s_tready_o[k]),
      .handshake_o(handshake[k]),
      .loaded_o   (loaded[k]),
      .field_o    (field[k])
    );
  end

  always_comb begin
    packed_fields = '0;
    for (int unsigned k = 0; k < NUM_FIELDS; k++) begin
      packed_fields[k*FIELD_WIDTH +: FIELD_WIDTH] = field[k];
    end
  end

  // COMPLETE is equivalent to all lanes loaded; no dependency on s_tvalid_i reaches ready.
  assign transfer = (state_q == PairHMMPackage::StComplete) && (!out_valid_q || !fifo_full_i);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      PairHMMPackage::StGather: begin
        if (&(loaded | handshake)) state_d = PairHMMPackage::StComplete;
      end
      PairHMMPackage::StComplete: begin
        if (transfer && !(&handshake)) state_d = PairHMMPackage::StGather;
      end
      default: state_d = PairHMMPackage::StGather;
    endcase
  end

  // Gated by reset so a pending word is discarded rather than written in the reset cycle.
  assign fifo_write = out_valid_q && !fifo_full_i && reset_n_i;

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    if (transfer) begin
      out_valid_d = 1'b1;
      out_data_d  = packed_fields;
    end else if (fifo_write) begin
      out_valid_d = 1'b0;
    end
    words_d = words_q + {31'd0, fifo_write};
  end

  always_ff @(posedge clock_i) begin
    if (!reset_n_i) begin
      state_q     <= PairHMMPackage::StGather;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      words_q     <= '0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      words_q     <= words_d;
    end
  end

  assign fifo_data_o     = out_data_q;
  assign fifo_write_o    = fifo_write;
  assign words_written_o = words_q;
  assign busy_o          = (|loaded) || out_valid_q;

endmodule
